// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC datapath: fetch T0-T2, decode T3, R-format execute T4-T5.
// Optional MUL/DIV support (extra T6 for the HI half) is enabled by defining CTRL_MULDIV_EN.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [4:0]  SEL_PC      = 5'b10100,
  parameter logic [4:0]  SEL_ZLO     = 5'b10011,
  parameter logic [4:0]  SEL_ZHI     = 5'b10010,
  parameter logic [4:0]  SEL_MDR     = 5'b10101
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [4:0]  BusDataSelect,
  output logic [3:0]  GP_addr,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        incPC,
  output logic        MDR_read,
  output logic [3:0]  ALU_op,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned CNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [4:0]  OP_HALT = 5'b11011;
  localparam logic [4:0]  OP_NOP  = 5'b11010;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             timeout_s;
  logic [4:0]       op_s;
  logic [3:0]       ra_s;
  logic [3:0]       rb_s;
  logic [3:0]       rc_s;
  logic             muldiv_s;
  logic             unused_s;

  function automatic logic is_alu_op(input logic [4:0] op);
    logic legal;
    legal = (op <= 5'd8);
`ifdef CTRL_MULDIV_EN
    legal = legal | (op == 5'b01111) | (op == 5'b10000);
`endif
    return legal;
  endfunction

  assign op_s      = ir[31:27];
  assign ra_s      = ir[26:23];
  assign rb_s      = ir[22:19];
  assign rc_s      = ir[18:15];
  assign unused_s  = ^ir[14:0];
  assign timeout_s = (wait_cnt_r == CNT_W'(MEM_TIMEOUT - 1));

`ifdef CTRL_MULDIV_EN
  assign muldiv_s = (op_s == 5'b01111) || (op_s == 5'b10000);
`else
  assign muldiv_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Memory wait counter: counts T1 cycles without mem_ready, zero everywhere else
  always_ff @(posedge clock) begin
    if (clear) begin
      wait_cnt_r <= '0;
    end else if ((state_r == S_T1) && !mem_ready && !timeout_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_s       = state_r;
    BusDataSelect = 5'b00000;
    GP_addr       = 4'b0000;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    MDR_read      = 1'b0;
    ALU_op        = 4'b0000;
    busy          = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run) begin
          state_s = S_T0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_T0: begin
        busy          = 1'b1;
        BusDataSelect = SEL_PC;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
        e_Z           = 1'b1;
        state_s       = S_T1;
      end
      S_T1: begin
        busy          = 1'b1;
        BusDataSelect = SEL_ZLO;
        e_PC          = 1'b1;
        MDR_read      = 1'b1;
        e_MDR         = 1'b1;
        if (mem_ready) begin
          state_s = S_T2;
        end else if (timeout_s) begin
          state_s = S_FAULT;
        end else begin
          state_s = S_T1;
        end
      end
      S_T2: begin
        busy          = 1'b1;
        BusDataSelect = SEL_MDR;
        e_IR          = 1'b1;
        state_s       = S_T3;
      end
      S_T3: begin
        busy = 1'b1;
        if (is_alu_op(op_s)) begin
          BusDataSelect = {1'b0, rb_s};
          e_Y           = 1'b1;
          state_s       = S_T4;
        end else if (op_s == OP_HALT) begin
          state_s = S_HALT;
        end else if (op_s == OP_NOP) begin
          state_s = run ? S_T0 : S_IDLE;
        end else begin
          state_s = S_FAULT;
        end
      end
      S_T4: begin
        busy          = 1'b1;
        BusDataSelect = {1'b0, rc_s};
        ALU_op        = op_s[3:0];
        e_Z           = 1'b1;
        state_s       = S_T5;
      end
      S_T5: begin
        busy          = 1'b1;
        BusDataSelect = SEL_ZLO;
        ALU_op        = op_s[3:0];
        if (muldiv_s) begin
          e_LO    = 1'b1;
          state_s = S_T6;
        end else begin
          GP_addr = ra_s;
          e_GP    = 1'b1;
          state_s = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        busy          = 1'b1;
        BusDataSelect = SEL_ZHI;
        e_HI          = 1'b1;
        state_s       = run ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_s = S_HALT;
      end
      S_FAULT: begin
        fault   = 1'b1;
        state_s = S_FAULT;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; compares the full control word each cycle
// against hand-computed values. Define CTRL_MULDIV_EN for both files to exercise the MUL/DIV path.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;
  logic [4:0]  BusDataSelect;
  logic [3:0]  GP_addr;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic        incPC, MDR_read, busy, halted, fault;
  logic [3:0]  ALU_op;
  logic [26:0] ctl;

  int checks_cnt;
  int errors_cnt;

  // enable vector order: {PC, IR, Y, Z, HI, LO, MDR, MAR, GP}
  localparam logic [8:0] EN_NONE = 9'b000000000;
  localparam logic [8:0] EN_PC   = 9'b100000000;
  localparam logic [8:0] EN_IR   = 9'b010000000;
  localparam logic [8:0] EN_Y    = 9'b001000000;
  localparam logic [8:0] EN_Z    = 9'b000100000;
  localparam logic [8:0] EN_HI   = 9'b000010000;
  localparam logic [8:0] EN_LO   = 9'b000001000;
  localparam logic [8:0] EN_MDR  = 9'b000000100;
  localparam logic [8:0] EN_MAR  = 9'b000000010;
  localparam logic [8:0] EN_GP   = 9'b000000001;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .BusDataSelect(BusDataSelect), .GP_addr(GP_addr),
    .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
    .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP),
    .incPC(incPC), .MDR_read(MDR_read), .ALU_op(ALU_op),
    .busy(busy), .halted(halted), .fault(fault)
  );

  assign ctl = {BusDataSelect, GP_addr, ALU_op,
                e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
                incPC, MDR_read, busy, halted, fault};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [26:0] cw(input logic [4:0] sel, input logic [3:0] gp,
                                     input logic [3:0] alu, input logic [8:0] en,
                                     input logic inc, input logic mdr, input logic bsy,
                                     input logic hlt, input logic flt);
    return {sel, gp, alu, en, inc, mdr, bsy, hlt, flt};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // caller has already clocked into T0
  task automatic fetch(input string tag);
    check_eq({tag, "_t0"}, 32'(ctl), 32'(cw(5'b10100, 4'h0, 4'h0, EN_Z | EN_MAR, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
    tick();
    check_eq({tag, "_t1"}, 32'(ctl), 32'(cw(5'b10011, 4'h0, 4'h0, EN_PC | EN_MDR, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)));
    tick();
    check_eq({tag, "_t2"}, 32'(ctl), 32'(cw(5'b10101, 4'h0, 4'h0, EN_IR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    tick();
  endtask

  // checks T3..T5 of an R-format ALU op; leaves the bench in T5
  task automatic exec_alu(input string tag, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rc, input logic [3:0] alu);
    check_eq({tag, "_t3"}, 32'(ctl), 32'(cw({1'b0, rb}, 4'h0, 4'h0, EN_Y, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    tick();
    check_eq({tag, "_t4"}, 32'(ctl), 32'(cw({1'b0, rc}, 4'h0, alu, EN_Z, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    tick();
    check_eq({tag, "_t5"}, 32'(ctl), 32'(cw(5'b10011, ra, alu, EN_GP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [26:0] w_busy3;
    logic [26:0] w_t1;
    checks_cnt = 0;
    errors_cnt = 0;
    w_busy3 = cw(5'b00000, 4'h0, 4'h0, EN_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    w_t1    = cw(5'b10011, 4'h0, 4'h0, EN_PC | EN_MDR, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    clear = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = 32'h0000_0000;
    tick();
    clear = 1'b0;
    check_eq("reset_idle", 32'(ctl), 32'h0);
    tick();
    check_eq("idle_hold", 32'(ctl), 32'h0);

    // SHL R4,R3,R7 with run held: back to T0 after T5
    ir = 32'h3A1B_8000; run = 1'b1;
    tick();
    fetch("shl");
    exec_alu("shl", 4'h4, 4'h3, 4'h7, 4'h7);
    tick();
    check_eq("shl_next_t0", 32'(ctl), 32'(cw(5'b10100, 4'h0, 4'h0, EN_Z | EN_MAR, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));

    // ADD R1,R2,R3 continuing from T0, run dropped in T5
    ir = 32'h0091_8000;
    tick();
    check_eq("add_t1", 32'(ctl), 32'(w_t1));
    tick(); tick();
    exec_alu("add", 4'h1, 4'h2, 4'h3, 4'h0);
    run = 1'b0;
    tick();
    check_eq("add_idle", 32'(ctl), 32'h0);
    check_eq("add_busy", 32'(busy), 32'h0);

    // SHRA R0,R9,R15 writes R0 like any other register
    ir = 32'h404F_8000; run = 1'b1;
    tick();
    fetch("shra");
    exec_alu("shra", 4'h0, 4'h9, 4'hF, 4'h8);
    run = 1'b0;
    tick();
    check_eq("shra_idle", 32'(ctl), 32'h0);

    // three wait cycles in T1: T1 held four cycles, then T2
    ir = 32'h0091_8000; run = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    check_eq("wait_t1_c1", 32'(ctl), 32'(w_t1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("wait_t1_held", 32'(ctl), 32'(w_t1));
    end
    mem_ready = 1'b1;
    tick();
    check_eq("wait_t2", 32'(ctl), 32'(cw(5'b10101, 4'h0, 4'h0, EN_IR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    run = 1'b0;
    tick(); tick(); tick();
    tick();
    check_eq("wait_idle", 32'(ctl), 32'h0);

    // timeout: 15 cycles in T1 without mem_ready, then FAULT
    run = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 14; i++) begin
      tick();
    end
    check_eq("tmo_last_t1", 32'(ctl), 32'(w_t1));
    tick();
    check_eq("tmo_fault", 32'(ctl), 32'(cw(5'b00000, 4'h0, 4'h0, EN_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
    run = 1'b0; mem_ready = 1'b1;
    tick();
    run = 1'b1;
    tick(); tick();
    check_eq("tmo_sticky", 32'(fault), 32'h1);
    check_eq("tmo_not_busy", 32'(busy), 32'h0);
    do_clear();
    check_eq("tmo_clear_idle", 32'(ctl), 32'h0);

    // HALT: no enables in T3, sticky until clear
    ir = 32'hD800_0000; run = 1'b1;
    tick();
    fetch("halt");
    check_eq("halt_t3", 32'(ctl), 32'(w_busy3));
    tick();
    check_eq("halt_state", 32'(ctl), 32'(cw(5'b00000, 4'h0, 4'h0, EN_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    check_eq("halt_sticky", 32'(halted), 32'h1);
    do_clear();
    check_eq("halt_clear_idle", 32'(ctl), 32'h0);

    // NOP: T3 -> T0 with run, -> IDLE without
    ir = 32'hD000_0000; run = 1'b1;
    tick();
    fetch("nop");
    check_eq("nop_t3", 32'(ctl), 32'(w_busy3));
    tick();
    check_eq("nop_t0", 32'(ctl), 32'(cw(5'b10100, 4'h0, 4'h0, EN_Z | EN_MAR, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
    run = 1'b0;
    tick(); tick(); tick();
    tick();
    check_eq("nop_idle", 32'(ctl), 32'h0);

    // clear in T4 wins
    ir = 32'h0091_8000; run = 1'b1;
    tick();
    fetch("clr");
    tick();
    check_eq("clr_t4_alu", 32'(ALU_op), 32'h0);
    check_eq("clr_t4_sel", 32'(BusDataSelect), 32'h03);
    do_clear();
    run = 1'b0;
    check_eq("clr_idle", 32'(ctl), 32'h0);

    // illegal op 01001 -> FAULT
    ir = 32'h4800_0000; run = 1'b1;
    tick();
    fetch("ill");
    check_eq("ill_t3", 32'(ctl), 32'(w_busy3));
    tick();
    check_eq("ill_fault", 32'(fault), 32'h1);
    do_clear();
    check_eq("ill_clear", 32'(ctl), 32'h0);

    // MUL R5,R6,R7 (op 01111)
    ir = 32'h7AB3_8000; run = 1'b1;
    tick();
    fetch("mul");
`ifdef CTRL_MULDIV_EN
    check_eq("mul_t3", 32'(ctl), 32'(cw(5'b00110, 4'h0, 4'h0, EN_Y, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    tick();
    check_eq("mul_t4", 32'(ctl), 32'(cw(5'b00111, 4'h0, 4'hF, EN_Z, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    tick();
    check_eq("mul_t5", 32'(ctl), 32'(cw(5'b10011, 4'h0, 4'hF, EN_LO, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    run = 1'b0;
    tick();
    check_eq("mul_t6", 32'(ctl), 32'(cw(5'b10010, 4'h0, 4'h0, EN_HI, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    tick();
    check_eq("mul_idle", 32'(ctl), 32'h0);
`else
    check_eq("mul_t3", 32'(ctl), 32'(w_busy3));
    tick();
    check_eq("mul_fault", 32'(ctl), 32'(cw(5'b00000, 4'h0, 4'h0, EN_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
